// File: rtl/fhe_alu_pkg.sv
// Shared FHE ALU sizing constants and the twiddle loader state encoding.
package fhe_alu_pkg;

  localparam int unsigned FSIZE = 32;
  localparam int unsigned E     = 8;
  localparam int unsigned LOG_E = 3;
  localparam int unsigned N     = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } tw_state_e;

endpackage

// File: rtl/twiddle_loader.sv
// Streams DMA beats into the per-stage W or WQ twiddle RAMs, one RAM row per beat,
// stage-major order, with registered write ports and last-beat framing check.
module twiddle_loader
  import fhe_alu_pkg::*;
#(
  parameter int unsigned FSIZE_P = FSIZE,
  parameter int unsigned LANES   = E / 2,
  parameter int unsigned STAGES  = LOG_E,
  parameter int unsigned DEPTH   = N / (E / 2)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              sel_wq,
  input  logic                              abort,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [LANES*FSIZE_P-1:0]          s_data,
  input  logic                              s_last,
  output logic [STAGES*$clog2(DEPTH)-1:0]   W_waddr,
  output logic [STAGES*$clog2(DEPTH)-1:0]   WQ_waddr,
  output logic [STAGES*LANES*FSIZE_P-1:0]   W_wdata,
  output logic [STAGES*LANES*FSIZE_P-1:0]   WQ_wdata,
  output logic [STAGES*LANES-1:0]           W_wren,
  output logic [STAGES*LANES-1:0]           WQ_wren,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned STG_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int unsigned BEAT_W = LANES * FSIZE_P;

  tw_state_e         state_q;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sel_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic load_c;
  logic beat_c;
  logic write_c;
  logic final_c;

  assign load_c  = (state_q == ST_LOAD);
  assign s_ready = load_c;
  assign beat_c  = load_c && s_valid;
  // An abort in the same cycle as a beat swallows that beat entirely.
  assign write_c = beat_c && !abort;
  assign final_c = (stage_q == STG_W'(STAGES - 1)) && (addr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    stage_d = stage_q;
    addr_d  = addr_q;
    if (addr_q == ADDR_W'(DEPTH - 1)) begin
      addr_d  = '0;
      stage_d = stage_q + STG_W'(1);
    end else begin
      addr_d  = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_LOAD;
            sel_q   <= sel_wq;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            stage_q <= '0;
            addr_q  <= '0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            stage_q <= '0;
            addr_q  <= '0;
          end else if (s_valid) begin
            if (s_last != final_c) err_q <= 1'b1;
            if (final_c) begin
              state_q <= ST_FLUSH;
              busy_q  <= 1'b0;
              stage_q <= '0;
              addr_q  <= '0;
              done_q  <= !err_q && s_last;
            end else begin
              stage_q <= stage_d;
              addr_q  <= addr_d;
            end
          end
        end
        ST_FLUSH: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Table 0 is W, table 1 is WQ; each holds its own registered write ports.
  for (genvar t = 0; t < 2; t++) begin : g_tbl
    logic [STAGES-1:0][ADDR_W-1:0] waddr_q;
    logic [STAGES-1:0][BEAT_W-1:0] wdata_q;
    logic [STAGES-1:0][LANES-1:0]  wren_q;
    logic [STAGES-1:0]             hit_c;

    always_comb begin
      hit_c = '0;
      for (int s = 0; s < STAGES; s++) begin
        hit_c[s] = write_c && (sel_q == 1'(t)) && (stage_q == STG_W'(s));
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        waddr_q <= '0;
        wdata_q <= '0;
        wren_q  <= '0;
      end else begin
        for (int s = 0; s < STAGES; s++) begin
          wren_q[s] <= {LANES{hit_c[s]}};
          if (hit_c[s]) begin
            waddr_q[s] <= addr_q;
            wdata_q[s] <= s_data;
          end
        end
      end
    end
  end

  assign W_waddr  = g_tbl[0].waddr_q;
  assign W_wdata  = g_tbl[0].wdata_q;
  assign W_wren   = g_tbl[0].wren_q;
  assign WQ_waddr = g_tbl[1].waddr_q;
  assign WQ_wdata = g_tbl[1].wdata_q;
  assign WQ_wren  = g_tbl[1].wren_q;

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_twiddle_loader.sv
// Table-driven load scenarios with a write scoreboard, plus hand-written reset sequences.
module tb_twiddle_loader;

  localparam int unsigned FS = 32;
  localparam int unsigned LN = 4;
  localparam int unsigned ST = 3;
  localparam int unsigned DP = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned BW = FS * LN;
  localparam int unsigned NB = ST * DP;

  logic clk = 1'b0;
  logic rst, start, sel_wq, abort, s_valid, s_ready, s_last;
  logic [BW-1:0]    s_data;
  logic [ST*AW-1:0] W_waddr, WQ_waddr;
  logic [ST*BW-1:0] W_wdata, WQ_wdata;
  logic [ST*LN-1:0] W_wren, WQ_wren;
  logic busy, done, err;

  twiddle_loader #(.FSIZE_P(FS), .LANES(LN), .STAGES(ST), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_wq(sel_wq), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .W_waddr(W_waddr), .WQ_waddr(WQ_waddr), .W_wdata(W_wdata), .WQ_wdata(WQ_wdata),
    .W_wren(W_wren), .WQ_wren(WQ_wren), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sel;
    logic bubble;
    int   last_at;
    int   abort_at;
    int   start_at;
    int   exp_wr;
    logic exp_done;
    logic exp_err;
  } vec_t;

  typedef struct {
    int            tbl;
    int            stage;
    int            addr;
    logic [BW-1:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   wcnt[2];
  int   done_cnt = 0;
  bit   sb_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every observed write must match the oldest outstanding accepted beat.
  always @(negedge clk) begin
    logic [LN-1:0] we;
    logic [AW-1:0] wa;
    logic [BW-1:0] wd;
    exp_t          e;
    if (sb_on) begin
      for (int t = 0; t < 2; t++) begin
        for (int s = 0; s < int'(ST); s++) begin
          we = (t == 1) ? WQ_wren[s*LN +: LN]  : W_wren[s*LN +: LN];
          wa = (t == 1) ? WQ_waddr[s*AW +: AW] : W_waddr[s*AW +: AW];
          wd = (t == 1) ? WQ_wdata[s*BW +: BW] : W_wdata[s*BW +: BW];
          if (we != '0) begin
            wcnt[t]++;
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL write_unexpected: got tbl%0d stg%0d addr%0d wren %h, expected no write",
                       t, s, wa, we);
            end else begin
              e = sb.pop_front();
              if (we !== 4'hF || t != e.tbl || s != e.stage || wa !== AW'(e.addr) || wd !== e.data) begin
                errors++;
                $display("FAIL write: got tbl%0d stg%0d addr%0d wren %h data %h, expected tbl%0d stg%0d addr%0d wren f data %h",
                         t, s, wa, we, wd, e.tbl, e.stage, e.addr, e.data);
              end
            end
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_load(input vec_t v);
    int k;
    int cyc;
    bit acc;
    bit ab;
    bit st_sent;
    done_cnt = 0;
    wcnt[0]  = 0;
    wcnt[1]  = 0;
    sel_wq = v.sel;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("err_cleared_by_start", 64'(err), 64'd0);
    k = 0;
    cyc = 0;
    st_sent = 1'b0;
    while (k < int'(NB) && cyc < 400) begin
      s_valid = v.bubble ? ((cyc % 2) == 0) : 1'b1;
      for (int i = 0; i < int'(LN); i++)
        s_data[i*FS +: FS] = FS'(k * 16 + i) | (v.sel ? 32'h8000_0000 : 32'h0);
      s_last = (v.last_at >= 0) ? (k == v.last_at) : (k == int'(NB) - 1);
      ab = s_valid && (k == v.abort_at);
      abort = ab;
      if (k == v.start_at && !st_sent) begin
        start   = 1'b1;
        sel_wq  = !v.sel;
        st_sent = 1'b1;
      end
      acc = s_valid && s_ready;
      if (acc && !ab) sb.push_back('{int'(v.sel), k / int'(DP), k % int'(DP), s_data});
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      cyc++;
      if (acc) begin
        if (ab) begin
          chk("abort_busy_low", 64'(busy), 64'd0);
          chk("abort_ready_low", 64'(s_ready), 64'd0);
          break;
        end
        k++;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (cyc >= 400) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got %0d beats, expected %0d", k, NB);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("writes_selected", 64'(wcnt[v.sel]), 64'(v.exp_wr));
    chk("writes_other_table", 64'(wcnt[!v.sel]), 64'd0);
    chk("done_pulses", 64'(done_cnt), 64'(v.exp_done));
    chk("err_flag", 64'(err), 64'(v.exp_err));
    chk("busy_idle", 64'(busy), 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, -1, -1, -1, 48, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, -1, -1, -1, 48, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 20, -1, -1, 48, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, -1, 10, -1, 10, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, -1, -1, -1, 48, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, -1, -1,  7, 48, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sel_wq = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_wren", 64'(W_wren), 64'd0);
    chk("rst_wq_wren", 64'(WQ_wren), 64'd0);
    chk("rst_waddr", 64'(W_waddr | WQ_waddr), 64'd0);
    chk("rst_wdata", 64'(|{W_wdata, WQ_wdata}), 64'd0);
    chk("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    sb_on = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_load(vecs[i]);

    // Asynchronous reset in the middle of a load.
    sb_on = 1'b0;
    sel_wq = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_w_wren", 64'(W_wren), 64'd0);
    chk("async_rst_wq_wren", 64'(WQ_wren), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_ready", 64'(s_ready), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    wcnt[0] = 0;
    wcnt[1] = 0;
    sb_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(s_ready), 64'd0);
    chk("post_rst_no_writes", 64'(wcnt[0] + wcnt[1]), 64'd0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    run_load(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/twiddle_loader.md
TWIDDLE_LOADER -- requirements
Module: twiddle_loader

Interface
REQ-001 SHALL have parameter FSIZE_P, default FSIZE (package), twiddle word width.
REQ-002 SHALL have parameter LANES, default E/2, words per beat (one per RAM lane).
REQ-003 SHALL have parameter STAGES, default logE, number of per-stage twiddle RAMs.
REQ-004 SHALL have parameter DEPTH, default N/(E/2), words-rows per stage RAM; ADDR_W = $clog2(DEPTH).
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  in  1  one-cycle load request, sampled in IDLE only.
REQ-008 SHALL have port sel_wq  in  1  target table, 0=W, 1=WQ, latched at start.
REQ-009 SHALL have port abort  in  1  terminate load, return to IDLE.
REQ-010 SHALL have port s_valid  in  1  DMA beat valid.
REQ-011 SHALL have port s_ready  out  1  beat accepted when s_valid&s_ready.
REQ-012 SHALL have port s_data  in  LANES*FSIZE_P  beat payload, lane i in slice i.
REQ-013 SHALL have port s_last  in  1  marks final beat of table.
REQ-014 SHALL have ports W_waddr/WQ_waddr  out  STAGES*ADDR_W  per-stage write address.
REQ-015 SHALL have ports W_wdata/WQ_wdata  out  STAGES*LANES*FSIZE_P  per-stage write data.
REQ-016 SHALL have ports W_wren/WQ_wren  out  STAGES*LANES  per-stage per-lane write enable.
REQ-017 SHALL have port busy  out  1  high in LOAD.
REQ-018 SHALL have port done  out  1  one-cycle pulse on successful completion.
REQ-019 SHALL have port err  out  1  sticky last-mismatch flag, cleared by next start.

Function
REQ-020 SHALL implement states IDLE, LOAD, FLUSH; IDLE->LOAD on start, LOAD->FLUSH on accepted beat STAGES*DEPTH-1, FLUSH->IDLE after one cycle.
REQ-021 SHALL assert s_ready combinationally iff state==LOAD.
REQ-022 SHALL keep beat counter k (width $clog2(STAGES*DEPTH)); stage = k/DEPTH, addr = k%DEPTH, tracked as separate stage and addr counters, addr wrapping DEPTH-1->0 with stage increment.
REQ-023 SHALL register each accepted beat: one cycle later the selected table's wren[stage] = all ones, waddr[stage] = addr, wdata[stage] = s_data; all other stages and the other table wren = 0.
REQ-024 SHALL hold waddr/wdata of idle stages at last value; only wren conveys validity.
REQ-025 SHALL tolerate s_valid bubbles: no beat, no write, counters hold.
REQ-026 SHALL set err if s_last=1 on a beat other than the final one, or s_last=0 on the final beat; load still completes by count.
REQ-027 SHALL pulse done in FLUSH only if err=0 for this load.
REQ-028 SHALL, on abort in LOAD, drop s_ready next cycle, suppress the write of any beat accepted that cycle, clear counters, go IDLE, not pulse done.
REQ-029 SHALL ignore start when not IDLE; abort has priority over a final beat in the same cycle.

Reset
REQ-030 SHALL on rst clear state to IDLE, counters, all wren, waddr, wdata, busy, done, err to 0 immediately, regardless of clock.
REQ-031 SHALL after reset mid-load require a fresh start; partial table contents are not rewritten.

Structure
REQ-032 SHALL take FSIZE, E, logE, N from FHE_ALU_PKG; no new package types beyond an enum for the three states added there.
REQ-033 SHALL be a single module, no sub-modules; output register arrays instantiated per table via generate.

Verification (bench: FSIZE_P=32, LANES=4, STAGES=3, DEPTH=16)
REQ-034 SHALL test full W load, 48 back-to-back beats data=k: W_wren[2]=4'hF with W_waddr[2]=15 one cycle after beat 47, done pulses once, WQ_wren never set.
REQ-035 SHALL test WQ load with s_valid toggling every other cycle: 48 writes total, beat 16 writes WQ stage1 addr0.
REQ-036 SHALL test s_last on beat 20: err=1, 48 writes occur, no done; next start clears err.
REQ-037 SHALL test abort on beat 10 cycle: no write for beat 10, busy=0 next cycle, no done, restart writes stage0 addr0.
REQ-038 SHALL test rst asserted mid-load asynchronously: all wren/busy 0 before next edge, start ignored in LOAD case verified separately.
